// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES round sequencer and its helpers.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} ctrl_state_e;

    typedef logic [127:0] block_t;
    typedef logic [3:0]   rnd_t;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    // Width of the wait-cycle timer; covers datapath latencies 1..7.
    localparam int TMR_W = 3;

    // Step encoding as seen by the key schedule: the direction flag sits above the step index.
    typedef struct packed {
        logic dec;
        rnd_t step;
    } step_enc_t;

    // Round-key index for a step: ascending for encrypt, descending NR..0 for decrypt.
    function automatic rnd_t step_to_rnd(input step_enc_t enc, input rnd_t nr);
        return enc.dec ? rnd_t'(nr - enc.step) : enc.step;
    endfunction

endpackage

// File: rtl/aes_step_timer.sv
// aes_step_timer: loadable down-counter that flags the last cycle of a datapath wait.
module aes_step_timer
    import aes_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [TMR_W-1:0] r_cnt;

    // Load on issue, count down while waiting, park at zero once expired.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (en_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - TMR_W'(1);
        end
    end

    assign expire_o = en_i && (r_cnt == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: accepts one 128-bit block, steps the shared round datapath NR+1 times
// (initial AddRoundKey, NR-1 full rounds, final round) and returns the result on valid/ready.
// Optional decrypt support is enabled with the AES_ROUND_CTRL_DEC_EN macro.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int DP_LAT = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
`ifdef AES_ROUND_CTRL_DEC_EN
    input  logic         in_dec_i,
`endif
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         dp_en_o,
    output logic [127:0] dp_state_o,
    output logic [3:0]   dp_rnd_o,
    output logic         dp_first_o,
    output logic         dp_last_o,
    input  logic [127:0] dp_state_i,
    output logic         busy_o
);

    localparam rnd_t             NR_R      = rnd_t'(NR);
    localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(DP_LAT - 1);

    ctrl_state_e r_state;
    block_t      r_data;
    rnd_t        r_step;
    logic        r_dec;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_dp_en;
    logic        r_first;
    logic        r_last;
    rnd_t        r_rnd;
    logic        r_busy;

    logic        w_in_dec;
    logic        w_accept;
    logic        w_expire;
    logic        w_step_last;
    rnd_t        w_step_nxt;

`ifdef AES_ROUND_CTRL_DEC_EN
    assign w_in_dec = in_dec_i;
`else
    assign w_in_dec = 1'b0;
`endif

    // in_ready is only ever high while idle, so it doubles as the accept qualifier.
    assign w_accept    = in_valid_i && r_in_ready;
    assign w_step_last = (r_step == NR_R);
    assign w_step_nxt  = r_step + 4'd1;

    aes_step_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (r_state == ISSUE),
        .load_val_i (WAIT_LAST),
        .en_i       (r_state == WAIT),
        .expire_o   (w_expire)
    );

    // Sequencer FSM; every output is registered and set alongside the transition that implies it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_step      <= '0;
            r_dec       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_dp_en     <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_rnd       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_dp_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= ISSUE;
                        r_data     <= in_data_i;
                        r_step     <= '0;
                        r_dec      <= w_in_dec;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dp_en    <= 1'b1;
                        r_first    <= 1'b1;
                        r_last     <= (NR_R == 4'd0);
                        r_rnd      <= step_to_rnd(step_enc_t'{dec: w_in_dec, step: 4'd0}, NR_R);
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_expire) begin
                        r_data <= dp_state_i;
                        if (w_step_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_first     <= 1'b0;
                            r_last      <= 1'b0;
                            r_rnd       <= '0;
                        end else begin
                            r_state <= ISSUE;
                            r_step  <= w_step_nxt;
                            r_dp_en <= 1'b1;
                            r_first <= 1'b0;
                            r_last  <= (w_step_nxt == NR_R);
                            r_rnd   <= step_to_rnd(step_enc_t'{dec: r_dec, step: w_step_nxt}, NR_R);
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_data;
    assign dp_en_o     = r_dp_en;
    assign dp_state_o  = r_data;
    assign dp_rnd_o    = r_rnd;
    assign dp_first_o  = r_first;
    assign dp_last_o   = r_last;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: bench for aes_round_ctrl with a golden AES round datapath (DP_LAT=1,
// NR=10) and a second instance on a 3-cycle stub datapath (DP_LAT=3, NR=14).
module tb_aes_round_ctrl;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rk    [16];
    logic         tb_dec = 1'b0;
    logic [127:0] exp_q [$];

    // ---------------- DUT A: NR=10, DP_LAT=1 ----------------
    logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [127:0] a_in_data = '0, a_out_data, a_dp_state, a_dp_res = '0;
    logic         a_dp_en, a_dp_first, a_dp_last, a_busy;
    logic [3:0]   a_dp_rnd;
`ifdef AES_ROUND_CTRL_DEC_EN
    logic         a_in_dec = 1'b0;
`endif

    aes_round_ctrl #(.NR(10), .DP_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
`ifdef AES_ROUND_CTRL_DEC_EN
        .in_dec_i(a_in_dec),
`endif
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .dp_en_o(a_dp_en), .dp_state_o(a_dp_state), .dp_rnd_o(a_dp_rnd),
        .dp_first_o(a_dp_first), .dp_last_o(a_dp_last), .dp_state_i(a_dp_res),
        .busy_o(a_busy)
    );

    // ---------------- DUT B: NR=14, DP_LAT=3 ----------------
    logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [127:0] b_in_data = '0, b_out_data, b_dp_state;
    logic [127:0] b_p1 = '0, b_p2 = '0, b_p3 = '0;
    logic         b_dp_en, b_dp_first, b_dp_last, b_busy;
    logic [3:0]   b_dp_rnd;
`ifdef AES_ROUND_CTRL_DEC_EN
    logic         b_in_dec = 1'b0;
`endif

    aes_round_ctrl #(.NR(14), .DP_LAT(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
`ifdef AES_ROUND_CTRL_DEC_EN
        .in_dec_i(b_in_dec),
`endif
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .dp_en_o(b_dp_en), .dp_state_o(b_dp_state), .dp_rnd_o(b_dp_rnd),
        .dp_first_o(b_dp_first), .dp_last_o(b_dp_last), .dp_state_i(b_p3),
        .busy_o(b_busy)
    );

    // ---------------- AES reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic build_keys(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One datapath step: AddRoundKey only on the first step, MixColumns skipped on the last.
    function automatic logic [127:0] dp_step(input logic [127:0] s, input logic [3:0] rnd,
                                             input logic first, input logic last, input logic dec);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        if (first) return s ^ rk[rnd];
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        if (!dec) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[b[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) b[r+4*c] = t[r+4*((c+r)%4)];
            if (!last) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                    b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
            return o ^ rk[rnd];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*((c+r)%4)] = b[r+4*c];
        for (int i = 0; i < 16; i++) b[i] = isbox[t[i]] ^ rk[rnd][127-8*i -: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                b[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                b[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                b[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                b[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt;
        for (int k = 0; k <= 10; k++) s = dp_step(s, 4'(k), k == 0, k == 10, 1'b0);
        return s;
    endfunction

    function automatic logic [127:0] stub(input logic [127:0] s, input logic [3:0] rnd,
                                          input logic first, input logic last);
        return {s[126:0], s[127]} ^ {32{rnd}} ^ {126'b0, first, last};
    endfunction

    // Golden datapath for DUT A: result valid one cycle after the enable pulse.
    always @(posedge clk) if (a_dp_en) a_dp_res <= dp_step(a_dp_state, a_dp_rnd, a_dp_first, a_dp_last, tb_dec);

    // Stub datapath for DUT B: three register stages.
    always @(posedge clk) begin
        b_p1 <= stub(b_dp_state, b_dp_rnd, b_dp_first, b_dp_last);
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end

    // Log of step controls seen on every enable pulse.
    logic [5:0] a_log [256];
    int         a_pulse_cnt = 0;
    int         b_pulse_cnt = 0;
    always @(posedge clk) begin
        if (a_dp_en) begin
            a_log[a_pulse_cnt % 256] <= {a_dp_rnd, a_dp_first, a_dp_last};
            a_pulse_cnt <= a_pulse_cnt + 1;
        end
        if (b_dp_en) b_pulse_cnt <= b_pulse_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_chk++;
        if ({a_in_ready, a_out_valid, a_dp_en, a_dp_first, a_dp_last, a_busy, a_dp_rnd} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0", {a_in_ready, a_out_valid, a_dp_en, a_dp_first, a_dp_last, a_busy, a_dp_rnd});
        end
        n_chk++;
        if ({a_out_data, a_dp_state} !== 256'b0) begin
            n_err++; $display("FAIL reset_data: got %h / %h required 0", a_out_data, a_dp_state);
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_release: in_ready=%b busy=%b required 1/0", a_in_ready, a_busy);
        end
    endtask

    task automatic run_block(input string name, input logic [127:0] blk, input logic [127:0] expv,
                             input logic dec, input int exp_lat);
        int cyc, base;
        base = a_pulse_cnt;
        exp_q.push_back(expv);
        a_in_data = blk; a_in_valid = 1'b1;
`ifdef AES_ROUND_CTRL_DEC_EN
        a_in_dec = dec;
`endif
        tick();
        a_in_valid = 1'b0;
        cyc = 1;
        n_chk++;
        if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
            n_err++; $display("FAIL %s_accept: busy=%b in_ready=%b required 1/0", name, a_busy, a_in_ready);
        end
        while (!a_out_valid && cyc < 200) begin tick(); cyc++; end
        n_chk++;
        if (cyc !== exp_lat) begin
            n_err++; $display("FAIL %s_latency: out_valid at cycle %0d required %0d", name, cyc, exp_lat);
        end
        n_chk++;
        if (a_out_data !== exp_q[0]) begin
            n_err++; $display("FAIL %s_data: got %h required %h", name, a_out_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        tick();
        n_chk++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_idle: out_valid=%b in_ready=%b required 0/1", name, a_out_valid, a_in_ready);
        end
        n_chk++;
        if (a_pulse_cnt - base !== 11) begin
            n_err++; $display("FAIL %s_pulses: got %0d required 11", name, a_pulse_cnt - base);
        end
        for (int i = 0; i < 11; i++) begin
            n_chk++;
            if (a_log[(base + i) % 256] !== {dec ? 4'(10 - i) : 4'(i), i == 0, i == 10}) begin
                n_err++;
                $display("FAIL %s_step%0d: rnd/first/last got %b required %b", name, i,
                         a_log[(base + i) % 256], {dec ? 4'(10 - i) : 4'(i), i == 0, i == 10});
            end
        end
`ifdef AES_ROUND_CTRL_DEC_EN
        a_in_dec = 1'b0;
`endif
    endtask

    task automatic test_fips();
        a_out_ready = 1'b1;
        run_block("fips", PT, CT, 1'b0, 23);
    endtask

    task automatic test_backpressure();
        logic [127:0] blk;
        int cyc, base;
        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_q.push_back(aes_enc(blk));
        base = a_pulse_cnt;
        a_out_ready = 1'b0;
        a_in_data = blk; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick(); tick();
        a_in_data = ~blk; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        cyc = 0;
        while (!a_out_valid && cyc < 200) begin tick(); cyc++; end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) a_in_valid = 1'b1;
            n_chk++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b in_ready=%b data=%h required 1/0/%h", i,
                         a_out_valid, a_in_ready, a_out_data, exp_q[0]);
            end
            tick();
            a_in_valid = 1'b0;
        end
        void'(exp_q.pop_front());
        a_out_ready = 1'b1;
        tick();
        n_chk++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            n_err++; $display("FAIL bp_release: valid=%b in_ready=%b busy=%b required 0/1/0", a_out_valid, a_in_ready, a_busy);
        end
        n_chk++;
        if (a_pulse_cnt - base !== 11) begin
            n_err++; $display("FAIL bp_pulses: got %0d required 11", a_pulse_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, base;
        base = a_pulse_cnt;
        exp_q.push_back(aes_enc(~PT));
        a_in_data = ~PT; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        cyc = 0;
        while (a_pulse_cnt < base + 6 && cyc < 100) begin tick(); cyc++; end
        n_chk++;
        if (a_dp_rnd !== 4'd5 || a_busy !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: rnd=%0d busy=%b required 5/1", a_dp_rnd, a_busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_chk++;
        if ({a_in_ready, a_out_valid, a_dp_en, a_dp_first, a_dp_last, a_busy, a_dp_rnd} !== 10'b0
            || a_out_data !== '0 || a_dp_state !== '0) begin
            n_err++;
            $display("FAIL mid_reset: ctrl=%b data=%h state=%h required all 0",
                     {a_in_ready, a_out_valid, a_dp_en, a_dp_first, a_dp_last, a_busy, a_dp_rnd}, a_out_data, a_dp_state);
        end
        tick();
        n_chk++;
        if (a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_ready: in_ready=%b required 1", a_in_ready);
        end
        run_block("mid_after", PT, CT, 1'b0, 23);
    endtask

    task automatic test_lat3();
        logic [127:0] blk, expv;
        int cyc, base;
        blk = {$urandom(), $urandom(), $urandom(), $urandom()};
        expv = blk;
        for (int k = 0; k <= 14; k++) expv = stub(expv, 4'(k), k == 0, k == 14);
        base = b_pulse_cnt;
        b_in_data = blk; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        cyc = 1;
        while (!b_out_valid && cyc < 300) begin tick(); cyc++; end
        n_chk++;
        if (cyc !== 61) begin
            n_err++; $display("FAIL lat3_latency: out_valid at cycle %0d required 61", cyc);
        end
        n_chk++;
        if (b_out_data !== expv) begin
            n_err++; $display("FAIL lat3_data: got %h required %h", b_out_data, expv);
        end
        n_chk++;
        if (b_pulse_cnt - base !== 15) begin
            n_err++; $display("FAIL lat3_pulses: got %0d required 15", b_pulse_cnt - base);
        end
        tick();
    endtask

`ifdef AES_ROUND_CTRL_DEC_EN
    task automatic test_decrypt();
        tb_dec = 1'b1;
        run_block("dec", CT, PT, 1'b1, 23);
        tb_dec = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [127:0] blk [3];
        int acc_cyc [3];
        int cyc, n_acc, n_out;
        for (int i = 0; i < 3; i++) blk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        a_out_ready = 1'b1;
        cyc = 0; n_acc = 0; n_out = 0;
        while (n_out < 3 && cyc < 200) begin
            a_in_valid = (n_acc < 3);
            a_in_data  = blk[n_acc % 3];
            if (a_out_valid) begin
                n_chk++;
                if (a_out_data !== exp_q[0]) begin
                    n_err++; $display("FAIL b2b_data%0d: got %h required %h", n_out, a_out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
                n_out++;
            end
            if (a_in_ready && a_in_valid) begin
                acc_cyc[n_acc] = cyc;
                exp_q.push_back(aes_enc(blk[n_acc]));
                n_acc++;
            end
            tick();
            cyc++;
        end
        a_in_valid = 1'b0;
        n_chk++;
        if (n_out !== 3 || n_acc !== 3) begin
            n_err++; $display("FAIL b2b_count: accepted %0d produced %0d required 3/3", n_acc, n_out);
        end else begin
            for (int i = 1; i < 3; i++) begin
                n_chk++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 24) begin
                    n_err++; $display("FAIL b2b_period%0d: got %0d required 24", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        build_tables();
        build_keys(KEY);
        test_reset();
        test_fips();
        test_backpressure();
        test_reset_mid();
        test_lat3();
`ifdef AES_ROUND_CTRL_DEC_EN
        test_decrypt();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
